btn_debounce_rpt: RTL and testbench



---
 rtl/btn_pkg.sv | 19 +
 rtl/btn_debounce_rpt_if.sv | 27 ++
 rtl/btn_chan.sv | 123 ++++++++++++
 rtl/btn_debounce_rpt.sv | 61 ++++++
 tb/tb_btn_debounce_rpt.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/btn_pkg.sv
// Shared types and constants for the button debounce / auto-repeat stage.
//   btn_state_t : per-channel FSM state (IDLE, HOLD, RPT)
//   HIST_LEN    : number of consecutive equal samples needed to change level
//   cnt_width() : counter width for a count range 0..n-1, at least 1 bit
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        RPT
    } btn_state_t;

    localparam int unsigned HIST_LEN = 3;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce_rpt_if.sv
// Button bundle between the raw push-button pins and the counter stages.
//   btn     : raw buttons, active-low, asynchronous to the system clock
//   btn_out : one-clock press / repeat pulse per button, active-high
//   btn_lvl : debounced pressed level per button, active-high
// master drives the raw buttons and observes the results; slave is the
// debouncer itself.
interface btn_debounce_rpt_if #(
    parameter int unsigned WIDTH = 3
);

    logic [WIDTH-1:0] btn;
    logic [WIDTH-1:0] btn_out;
    logic [WIDTH-1:0] btn_lvl;

    modport master (
        output btn,
        input  btn_out,
        input  btn_lvl
    );

    modport slave (
        input  btn,
        output btn_out,
        output btn_lvl
    );

endinterface

// File: rtl/btn_chan.sv
// Single button channel: 2-flop synchroniser, sampled debounce history,
// press-edge detection and optional auto-repeat while held.
//   clk      : system clock
//   n_rst    : asynchronous active-low reset
//   btn_i    : raw button, active-low
//   tick_i   : one-clock sample strobe shared by all channels
//   rpt_en_i : enables auto-repeat while the button is held
//   pulse_o  : registered one-clock press / repeat pulse
//   lvl_o    : registered debounced pressed level
module btn_chan
    import btn_pkg::*;
#(
    parameter int unsigned REPEAT_DLY = 50,
    parameter int unsigned REPEAT_PER = 20
) (
    input  logic clk,
    input  logic n_rst,
    input  logic btn_i,
    input  logic tick_i,
    input  logic rpt_en_i,
    output logic pulse_o,
    output logic lvl_o
);

    localparam int unsigned RMAX   = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int unsigned RCNT_W = cnt_width(RMAX);

    localparam logic [RCNT_W-1:0] DLY_LAST = RCNT_W'(REPEAT_DLY - 1);
    localparam logic [RCNT_W-1:0] PER_LAST = RCNT_W'(REPEAT_PER - 1);

    logic                sync1_q;
    logic                sync2_q;
    logic [HIST_LEN-1:0] hist_q;
    logic [HIST_LEN-1:0] hist_d;
    logic                all_prs;
    logic                all_rel;
    btn_state_t          state_q;
    logic [RCNT_W-1:0]   rcnt_q;
    logic                pulse_q;
    logic                lvl_q;

    // Decisions are taken on the history as it will be after this tick,
    // so level and pulse land together on the clock after the tick.
    always_comb begin
        hist_d  = {hist_q[HIST_LEN-2:0], sync2_q};
        all_prs = (hist_d == '0);
        all_rel = (hist_d == '1);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            hist_q  <= '1;
            state_q <= IDLE;
            rcnt_q  <= '0;
            pulse_q <= 1'b0;
            lvl_q   <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            pulse_q <= 1'b0;

            if (tick_i) begin
                hist_q <= hist_d;

                if (all_prs) begin
                    lvl_q <= 1'b1;
                end else if (all_rel) begin
                    lvl_q <= 1'b0;
                end

                case (state_q)
                    IDLE: begin
                        if (all_prs) begin
                            pulse_q <= 1'b1;
                            rcnt_q  <= '0;
                            state_q <= HOLD;
                        end
                    end

                    HOLD: begin
                        // Release is checked first so it wins over a
                        // coincident repeat pulse.
                        if (all_rel) begin
                            rcnt_q  <= '0;
                            state_q <= IDLE;
                        end else if (rpt_en_i) begin
                            if (rcnt_q == DLY_LAST) begin
                                pulse_q <= 1'b1;
                                rcnt_q  <= '0;
                                state_q <= RPT;
                            end else begin
                                rcnt_q <= rcnt_q + RCNT_W'(1);
                            end
                        end
                    end

                    RPT: begin
                        if (all_rel) begin
                            rcnt_q  <= '0;
                            state_q <= IDLE;
                        end else if (rcnt_q == PER_LAST) begin
                            pulse_q <= 1'b1;
                            rcnt_q  <= '0;
                        end else begin
                            rcnt_q <= rcnt_q + RCNT_W'(1);
                        end
                    end

                    default: begin
                        rcnt_q  <= '0;
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign pulse_o = pulse_q;
    assign lvl_o   = lvl_q;

endmodule

// File: rtl/btn_debounce_rpt.sv
// Push-button input stage for the clock/timer tops: turns raw active-low
// buttons into clean one-clock press pulses, with optional auto-repeat.
//   clk   : system clock
//   n_rst : asynchronous active-low reset
//   bif   : button bundle (slave): btn in, btn_out / btn_lvl out
// A single free-running sample tick is shared by every channel.
module btn_debounce_rpt
    import btn_pkg::*;
#(
    parameter int unsigned     WIDTH      = 3,
    parameter int unsigned     SAMPLE_CYC = 500000,
    parameter int unsigned     REPEAT_DLY = 50,
    parameter int unsigned     REPEAT_PER = 20,
    parameter logic [WIDTH-1:0] REPEAT_EN = '0
) (
    input  logic                clk,
    input  logic                n_rst,
    btn_debounce_rpt_if.slave   bif
);

    localparam int unsigned        TCNT_W    = cnt_width(SAMPLE_CYC);
    localparam logic [TCNT_W-1:0]  TCNT_LAST = TCNT_W'(SAMPLE_CYC - 1);

    logic [TCNT_W-1:0] tcnt_q;
    logic [TCNT_W-1:0] tcnt_d;
    logic              tick;
    logic [WIDTH-1:0]  out_w;
    logic [WIDTH-1:0]  lvl_w;

    always_comb begin
        tick   = (tcnt_q == TCNT_LAST);
        tcnt_d = tick ? '0 : tcnt_q + TCNT_W'(1);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            tcnt_q <= '0;
        end else begin
            tcnt_q <= tcnt_d;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        btn_chan #(
            .REPEAT_DLY (REPEAT_DLY),
            .REPEAT_PER (REPEAT_PER)
        ) u_chan (
            .clk      (clk),
            .n_rst    (n_rst),
            .btn_i    (bif.btn[i]),
            .tick_i   (tick),
            .rpt_en_i (REPEAT_EN[i]),
            .pulse_o  (out_w[i]),
            .lvl_o    (lvl_w[i])
        );
    end

    assign bif.btn_out = out_w;
    assign bif.btn_lvl = lvl_w;

endmodule

// File: tb/tb_btn_debounce_rpt.sv
// Directed bench for btn_debounce_rpt with SAMPLE_CYC=4, REPEAT_DLY=3,
// REPEAT_PER=2, REPEAT_EN=3'b010. Edge numbers count rising clock edges
// since the most recent reset release; sample ticks fall on multiples of 4.
module tb_btn_debounce_rpt;

    logic clk = 1'b0;
    logic n_rst;

    always #5 clk = ~clk;

    btn_debounce_rpt_if #(.WIDTH(3)) bif ();

    btn_debounce_rpt #(
        .WIDTH      (3),
        .SAMPLE_CYC (4),
        .REPEAT_DLY (3),
        .REPEAT_PER (2),
        .REPEAT_EN  (3'b010)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bif   (bif)
    );

    int n_assert = 0;
    int n_fail   = 0;

    int       edge_n;
    int       pcnt [3];
    int       pe [3][8];
    int       lvl_rise [3];
    int       lvl_fall [3];
    int       all3_edge;
    int       tick_err = 0;
    int       consec_err = 0;
    logic [2:0] lvl_seen;
    logic [2:0] prev_out;
    logic [2:0] prev_lvl;

    int exp_p4 [5] = '{372, 384, 392, 400, 408};
    int exp_p5 [5] = '{452, 464, 472, 480, 488};
    int exp_p6 [3] = '{12, 24, 32};

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_rec();
        for (int b = 0; b < 3; b++) begin
            pcnt[b]     = 0;
            lvl_rise[b] = -1;
            lvl_fall[b] = -1;
            for (int k = 0; k < 8; k++) pe[b][k] = -1;
        end
        all3_edge = -1;
        lvl_seen  = '0;
    endtask

    // Advance n clocks, sampling outputs 1 time unit after each rising edge.
    task automatic cycles(input int n);
        logic exp_tick;
        repeat (n) begin
            @(posedge clk);
            edge_n++;
            #1;
            exp_tick = ((edge_n + 1) % 4 == 0);
            if (dut.tick !== exp_tick) tick_err++;
            for (int b = 0; b < 3; b++) begin
                if (bif.btn_out[b] === 1'b1) begin
                    if (pcnt[b] < 8) pe[b][pcnt[b]] = edge_n;
                    pcnt[b]++;
                    if (prev_out[b] === 1'b1) consec_err++;
                end
                if (bif.btn_lvl[b] === 1'b1 && prev_lvl[b] !== 1'b1 && lvl_rise[b] < 0)
                    lvl_rise[b] = edge_n;
                if (bif.btn_lvl[b] === 1'b0 && prev_lvl[b] === 1'b1 && lvl_fall[b] < 0)
                    lvl_fall[b] = edge_n;
                if (bif.btn_lvl[b] !== 1'b0) lvl_seen[b] = 1'b1;
            end
            if (bif.btn_out === 3'b111 && all3_edge < 0) all3_edge = edge_n;
            prev_out = bif.btn_out;
            prev_lvl = bif.btn_lvl;
        end
    endtask

    initial begin
        n_rst   = 1'b0;
        bif.btn = 3'b111;
        clear_rec();

        // Reset state
        #12;
        chk("rst_out", int'(bif.btn_out), 0);
        chk("rst_lvl", int'(bif.btn_lvl), 0);
        @(negedge clk);
        n_rst    = 1'b1;
        edge_n   = 0;
        prev_out = '0;
        prev_lvl = '0;

        // 1: idle buttons
        cycles(100);
        chk("p1_pulses", pcnt[0] + pcnt[1] + pcnt[2], 0);
        chk("p1_lvl", int'(lvl_seen), 0);
        chk("p1_tick", tick_err, 0);

        // 2: steady press on bit 0 (no repeat)
        clear_rec();
        bif.btn = 3'b110;
        cycles(200);
        chk("p2_cnt0", pcnt[0], 1);
        chk("p2_edge0", pe[0][0], 112);
        chk("p2_rise0", lvl_rise[0], 112);
        chk("p2_others", pcnt[1] + pcnt[2], 0);
        chk("p2_lvl", int'(bif.btn_lvl), 1);

        clear_rec();
        bif.btn = 3'b111;
        cycles(20);
        chk("p2r_cnt0", pcnt[0], 0);
        chk("p2r_fall0", lvl_fall[0], 312);
        chk("p2r_lvl", int'(bif.btn_lvl), 0);

        // 3: bounce on bit 0, never three equal pressed samples
        clear_rec();
        bif.btn = 3'b110;
        cycles(6);
        bif.btn = 3'b111;
        cycles(4);
        bif.btn = 3'b110;
        cycles(6);
        bif.btn = 3'b111;
        cycles(24);
        chk("p3_cnt0", pcnt[0], 0);
        chk("p3_lvl", int'(lvl_seen), 0);

        // 4: hold bit 1 (repeat enabled), then release
        clear_rec();
        bif.btn = 3'b101;
        cycles(42);
        bif.btn = 3'b111;
        cycles(38);
        chk("p4_cnt1", pcnt[1], 5);
        for (int k = 0; k < 5; k++) chk($sformatf("p4_edge1_%0d", k), pe[1][k], exp_p4[k]);
        chk("p4_rise1", lvl_rise[1], 372);
        chk("p4_fall1", lvl_fall[1], 416);
        chk("p4_others", pcnt[0] + pcnt[2], 0);

        // 5: all three pressed together
        clear_rec();
        bif.btn = 3'b000;
        cycles(50);
        chk("p5_all3", all3_edge, 452);
        chk("p5_cnt0", pcnt[0], 1);
        chk("p5_cnt2", pcnt[2], 1);
        chk("p5_cnt1", pcnt[1], 5);
        for (int k = 0; k < 5; k++) chk($sformatf("p5_edge1_%0d", k), pe[1][k], exp_p5[k]);
        chk("p5_lvl", int'(bif.btn_lvl), 7);

        // 6: reset mid-repeat with buttons still held
        n_rst = 1'b0;
        #2;
        chk("p6_async_out", int'(bif.btn_out), 0);
        chk("p6_async_lvl", int'(bif.btn_lvl), 0);
        repeat (3) @(negedge clk);
        n_rst    = 1'b1;
        edge_n   = 0;
        prev_out = '0;
        prev_lvl = '0;
        clear_rec();
        cycles(36);
        chk("p6_cnt1", pcnt[1], 3);
        for (int k = 0; k < 3; k++) chk($sformatf("p6_edge1_%0d", k), pe[1][k], exp_p6[k]);
        chk("p6_cnt0", pcnt[0], 1);
        chk("p6_edge0", pe[0][0], 12);
        chk("p6_cnt2", pcnt[2], 1);
        chk("p6_rise1", lvl_rise[1], 12);
        chk("consec", consec_err, 0);
        chk("tick_all", tick_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
